// File: rtl/fcvt_f2i_pipe.sv
// Pipelined binary32 -> XLEN-bit integer converter (FCVT.W[U].S / FCVT.L[U].S); NV/NX flags only when FCVT_F2I_FLAGS_EN is defined.
// Latency 2 (S1 unpack/align, S2 round/saturate); stalls on out_ready low, holding up to 2 ops, and in_ready never depends on in_valid.
module fcvt_f2i_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      float_in,
  input  logic [2:0]       rm,
  input  logic             is_unsigned,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic [4:0]       fflags
);
  localparam int IW   = XLEN + 2;
  localparam int FRAC = 26;
  localparam int FXW  = IW + FRAC;
  localparam int RW   = IW + 1;
  // Any exponent above this cannot fit in IW integer bits.
  localparam logic [7:0]      HUGE_EXP = 8'(128 + XLEN);
  localparam logic [RW-1:0]   LIM_S    = RW'(1) << (XLEN - 1);
  localparam logic [RW-1:0]   LIM_U    = RW'(1) << XLEN;
  localparam logic [XLEN-1:0] MAX_S    = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic [XLEN-1:0] MIN_S    = {1'b1, {(XLEN-1){1'b0}}};

  logic adv1, adv2, s1_valid;

  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  logic            f_sign;
  logic [7:0]      f_exp;
  logic [22:0]     f_man;
  logic [7:0]      sh;
  logic [FXW-1:0]  fx;
  logic            a_nan, a_ovf, a_g, a_r, a_s;
  logic [IW-1:0]   a_mag;

  assign f_sign = float_in[31];
  assign f_exp  = float_in[30:23];
  assign f_man  = float_in[22:0];
  // Place the significand so the binary point sits FRAC bits above the LSB.
  assign sh     = f_exp - 8'd124;
  assign fx     = {{(FXW-24){1'b0}}, 1'b1, f_man} << sh;

  always_comb begin
    a_nan = (f_exp == 8'hFF) & (|f_man);
    a_ovf = (f_exp > HUGE_EXP) & ~a_nan;
    a_mag = '0;
    a_g   = 1'b0;
    a_r   = 1'b0;
    a_s   = 1'b0;
    if (f_exp <= HUGE_EXP) begin
      if (f_exp < 8'd126) begin
        a_s = (f_exp != 8'd0) | (|f_man);
      end else begin
        a_mag = fx[FXW-1:FRAC];
        a_g   = fx[FRAC-1];
        a_r   = fx[FRAC-2];
        a_s   = |fx[FRAC-3:0];
      end
    end
  end

  logic             s1_sign, s1_nan, s1_ovf, s1_g, s1_r, s1_s, s1_uns;
  logic [IW-1:0]    s1_mag;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_g     <= 1'b0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_uns   <= 1'b0;
      s1_mag   <= '0;
      s1_rm    <= 3'b000;
      s1_tag   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= f_sign;
        s1_nan  <= a_nan;
        s1_ovf  <= a_ovf;
        s1_g    <= a_g;
        s1_r    <= a_r;
        s1_s    <= a_s;
        s1_uns  <= is_unsigned;
        s1_mag  <= a_mag;
        s1_rm   <= rm;
        s1_tag  <= tag_in;
      end
    end
  end

  logic            rs, inexact, inc;
  logic [RW-1:0]   rnd;
  logic            over_s, over_u, over, pos_sat, neg_sat, zero_sat;
  logic [XLEN-1:0] res_d;

  assign rs      = s1_r | s1_s;
  assign inexact = s1_g | rs;

  always_comb begin
    case (s1_rm)
      3'b000:  inc = s1_g & (rs | s1_mag[0]);
      3'b010:  inc = s1_sign & inexact;
      3'b011:  inc = ~s1_sign & inexact;
      3'b100:  inc = s1_g;
      default: inc = 1'b0;
    endcase
  end

  assign rnd = {1'b0, s1_mag} + {{(RW-1){1'b0}}, inc};

  // Range is judged on the rounded magnitude together with the sign.
  assign over_s   = s1_ovf | (s1_sign ? (rnd > LIM_S) : (rnd >= LIM_S));
  assign over_u   = s1_ovf | (s1_sign ? (rnd != '0) : (rnd >= LIM_U));
  assign over     = s1_uns ? over_u : over_s;
  assign pos_sat  = s1_nan | (~s1_sign & over);
  assign neg_sat  = ~s1_nan & s1_sign & over & ~s1_uns;
  assign zero_sat = ~s1_nan & s1_sign & over & s1_uns;

  always_comb begin
    if (pos_sat)       res_d = s1_uns ? {XLEN{1'b1}} : MAX_S;
    else if (neg_sat)  res_d = MIN_S;
    else if (zero_sat) res_d = '0;
    else if (s1_sign)  res_d = {XLEN{1'b0}} - rnd[XLEN-1:0];
    else               res_d = rnd[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      tag_out   <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= res_d;
        tag_out <= s1_tag;
      end
    end
  end

`ifdef FCVT_F2I_FLAGS_EN
  logic nv_d, nx_d;

  assign nv_d = pos_sat | neg_sat | zero_sat;
  assign nx_d = inexact & ~nv_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                fflags <= 5'b0;
    else if (adv2 && s1_valid)   fflags <= {nv_d, 3'b000, nx_d};
  end
`else
  assign fflags = 5'b0;
`endif

endmodule

// File: tb/tb_fcvt_f2i_pipe.sv
// Scoreboard bench for fcvt_f2i_pipe: XLEN=32 and XLEN=64 instances share stimulus and handshake.
module tb_fcvt_f2i_pipe;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, out_ready, is_unsigned;
  logic [31:0] float_in;
  logic [2:0]  rm;
  logic [4:0]  tag_in;
  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] result;
  logic [63:0] result64;
  logic [4:0]  tag_out, tag_out64, fflags, fflags64;

  always #5 clk = ~clk;

  fcvt_f2i_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .float_in(float_in), .rm(rm), .is_unsigned(is_unsigned), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .fflags(fflags));

  fcvt_f2i_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .float_in(float_in), .rm(rm), .is_unsigned(is_unsigned), .tag_in(tag_in),
    .out_valid(out_valid64), .out_ready(out_ready), .result(result64),
    .tag_out(tag_out64), .fflags(fflags64));

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  fl;
    logic [4:0]  tag;
  } exp_t;

  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] NX = 5'b00001;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   vectors = 0;
  int   errs    = 0;

  function automatic logic [4:0] flg(input logic [4:0] x);
`ifdef FCVT_F2I_FLAGS_EN
    flg = x;
`else
    flg = x & 5'b00000;
`endif
  endfunction

  // Reference built on real arithmetic, independent of the shifter/rounder structure.
  function automatic exp_t model(input logic [31:0] f, input logic [2:0] r, input logic u,
                                 input logic [4:0] t, input int xl);
    exp_t   e;
    real    v, fl, fr, rr;
    int     ex, mv;
    logic   nv, nx;
    longint li;
    logic [63:0] maxp, minn;
    maxp = (xl == 32) ? (u ? 64'hFFFF_FFFF : 64'h7FFF_FFFF)
                      : (u ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF);
    minn = (xl == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
    e.tag = t;
    e.res = '0;
    nv = 1'b0;
    nx = 1'b0;
    ex = int'(f[30:23]);
    if (ex == 255) begin
      nv = 1'b1;
      if (f[22:0] != 23'd0 || !f[31]) e.res = maxp;
      else                            e.res = u ? 64'd0 : minn;
    end else begin
      mv = (ex == 0) ? int'(f[22:0]) : int'(f[22:0]) + 8388608;
      v  = mv;
      v  = v * (2.0 ** ((ex == 0) ? -149 : ex - 150));
      if (f[31]) v = -v;
      fl = $floor(v);
      fr = v - fl;
      case (r)
        3'd0:    rr = (fr > 0.5 || (fr == 0.5 && $floor(fl / 2.0) * 2.0 != fl)) ? fl + 1.0 : fl;
        3'd2:    rr = fl;
        3'd3:    rr = (fr > 0.0) ? fl + 1.0 : fl;
        3'd4:    rr = (v >= 0.0) ? ((fr >= 0.5) ? fl + 1.0 : fl) : ((fr > 0.5) ? fl + 1.0 : fl);
        default: rr = (v < 0.0 && fr > 0.0) ? fl + 1.0 : fl;
      endcase
      if (u) begin
        if (rr >= 2.0 ** xl) begin nv = 1'b1; e.res = maxp; end
        else if (rr < 0.0)   begin nv = 1'b1; e.res = 64'd0; end
      end else begin
        if (rr >= 2.0 ** (xl - 1))       begin nv = 1'b1; e.res = maxp; end
        else if (rr < -(2.0 ** (xl - 1))) begin nv = 1'b1; e.res = minn; end
      end
      if (!nv) begin
        nx = (fr != 0.0);
        if (rr >= 9223372036854775808.0) li = rr - 18446744073709551616.0;
        else                              li = rr;
        e.res = li;
      end
    end
    e.fl = flg({nv, 3'b000, nx});
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      vectors++;
      if (q32.size() == 0) begin
        errs++;
        $display("FAIL extra32 tag=%0d result=%h required=no output", tag_out, result);
      end else begin
        e32 = q32.pop_front();
        if (result !== e32.res[31:0] || fflags !== e32.fl || tag_out !== e32.tag) begin
          errs++;
          $display("FAIL out32 tag got=%0d req=%0d result got=%h req=%h fflags got=%b req=%b",
                   tag_out, e32.tag, result, e32.res[31:0], fflags, e32.fl);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid64 && out_ready) begin
      vectors++;
      if (q64.size() == 0) begin
        errs++;
        $display("FAIL extra64 tag=%0d result=%h required=no output", tag_out64, result64);
      end else begin
        e64 = q64.pop_front();
        if (result64 !== e64.res || fflags64 !== e64.fl || tag_out64 !== e64.tag) begin
          errs++;
          $display("FAIL out64 tag got=%0d req=%0d result got=%h req=%h fflags got=%b req=%b",
                   tag_out64, e64.tag, result64, e64.res, fflags64, e64.fl);
        end
      end
    end
  end

  // Offer one op, push its expectations when it will be accepted, release a stalled consumer.
  task automatic send(input logic [31:0] f, input logic [2:0] r, input logic u, input logic [4:0] t,
                      input logic known, input logic [31:0] kres, input logic [4:0] kfl);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1; float_in = f; rm = r; is_unsigned = u; tag_in = t;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    vectors++;
    if (!ok) begin
      errs++;
      $display("FAIL accept_timeout tag=%0d in_ready=%b required=1", t, in_ready);
    end else begin
      e = model(f, r, u, t, 32);
      if (known) begin
        e.res = {32'h0, kres};
        e.fl  = flg(kfl);
      end
      q32.push_back(e);
      q64.push_back(model(f, r, u, t, 64));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q32.size() == 0 && q64.size() == 0) break;
    end
    vectors++;
    if (q32.size() != 0 || q64.size() != 0) begin
      errs++;
      $display("FAIL drain pending32=%0d pending64=%0d required=0", q32.size(), q64.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || tag_out !== 5'h0 ||
        fflags !== 5'h0 || out_valid64 !== 1'b0 || result64 !== 64'h0) begin
      errs++;
      $display("FAIL reset_state out_valid=%b in_ready=%b result=%h tag=%h fflags=%b required 0,1,0,0,0",
               out_valid, in_ready, result, tag_out, fflags);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_directed();
    send(32'h40200000, 3'd0, 1'b0, 5'd1, 1'b1, 32'd2, NX);
    send(32'h40200000, 3'd1, 1'b0, 5'd2, 1'b1, 32'd2, NX);
    send(32'h40200000, 3'd2, 1'b0, 5'd3, 1'b1, 32'd2, NX);
    send(32'h40200000, 3'd3, 1'b0, 5'd4, 1'b1, 32'd3, NX);
    send(32'h40200000, 3'd4, 1'b0, 5'd5, 1'b1, 32'd3, NX);
    send(32'h40200000, 3'd6, 1'b0, 5'd6, 1'b1, 32'd2, NX);
    send(32'hC0200000, 3'd2, 1'b0, 5'd7, 1'b1, 32'hFFFFFFFD, NX);
    send(32'hC0200000, 3'd1, 1'b0, 5'd8, 1'b1, 32'hFFFFFFFE, NX);
    send(32'hC0200000, 3'd0, 1'b0, 5'd9, 1'b1, 32'hFFFFFFFE, NX);
    send(32'hC0200000, 3'd4, 1'b0, 5'd10, 1'b1, 32'hFFFFFFFD, NX);
    send(32'h4F32D05E, 3'd0, 1'b0, 5'd11, 1'b1, 32'h7FFFFFFF, NV);
    send(32'h4F32D05E, 3'd0, 1'b1, 5'd12, 1'b1, 32'hB2D05E00, 5'b0);
    send(32'h7FC00000, 3'd0, 1'b0, 5'd13, 1'b1, 32'h7FFFFFFF, NV);
    send(32'h7FC00000, 3'd0, 1'b1, 5'd14, 1'b1, 32'hFFFFFFFF, NV);
    send(32'hFF800000, 3'd0, 1'b1, 5'd15, 1'b1, 32'h00000000, NV);
    send(32'hFF800000, 3'd0, 1'b0, 5'd16, 1'b1, 32'h80000000, NV);
    send(32'hBE99999A, 3'd1, 1'b1, 5'd17, 1'b1, 32'h00000000, NX);
    send(32'hBF800000, 3'd0, 1'b1, 5'd18, 1'b1, 32'h00000000, NV);
    send(32'h80000000, 3'd0, 1'b0, 5'd19, 1'b1, 32'h00000000, 5'b0);
    send(32'h80000000, 3'd2, 1'b1, 5'd20, 1'b1, 32'h00000000, 5'b0);
    send(32'hCF000000, 3'd0, 1'b0, 5'd21, 1'b1, 32'h80000000, 5'b0);
    send(32'h4F000000, 3'd0, 1'b0, 5'd22, 1'b1, 32'h7FFFFFFF, NV);
    send(32'h4F000000, 3'd0, 1'b1, 5'd23, 1'b1, 32'h80000000, 5'b0);
    send(32'h4F7FFFFF, 3'd1, 1'b1, 5'd24, 1'b1, 32'hFFFFFF00, 5'b0);
    send(32'h3F000000, 3'd0, 1'b0, 5'd25, 1'b1, 32'd0, NX);
    send(32'h3F000000, 3'd4, 1'b0, 5'd26, 1'b1, 32'd1, NX);
    send(32'h3FC00000, 3'd0, 1'b0, 5'd27, 1'b1, 32'd2, NX);
    send(32'h00000001, 3'd3, 1'b0, 5'd28, 1'b1, 32'd1, NX);
    send(32'h80000001, 3'd2, 1'b0, 5'd29, 1'b1, 32'hFFFFFFFF, NX);
    send(32'hBF000000, 3'd0, 1'b1, 5'd30, 1'b1, 32'd0, NX);
    send(32'hBF000000, 3'd2, 1'b1, 5'd31, 1'b1, 32'd0, NV);
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    logic [4:0]  t0, f0;
    out_ready = 1'b0;
    send(32'h3F800000, 3'd0, 1'b0, 5'd1, 1'b0, 32'h0, 5'h0);
    send(32'h40000000, 3'd0, 1'b0, 5'd2, 1'b0, 32'h0, 5'h0);
    in_valid = 1'b1; float_in = 32'h40400000; rm = 3'd0; is_unsigned = 1'b0; tag_in = 5'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL stall_ready cycle=%0d in_ready=%b out_valid=%b required 0,1", c, in_ready, out_valid);
      end
      if (c == 0) begin
        r0 = result; t0 = tag_out; f0 = fflags;
        vectors++;
        if (tag_out !== 5'd1) begin
          errs++;
          $display("FAIL stall_head tag got=%0d required=1", tag_out);
        end
      end else begin
        vectors++;
        if (result !== r0 || tag_out !== t0 || fflags !== f0) begin
          errs++;
          $display("FAIL stall_stable result=%h/%h tag=%0d/%0d fflags=%b/%b", result, r0, tag_out, t0, fflags, f0);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h40400000, 3'd0, 1'b0, 5'd3, 1'b0, 32'h0, 5'h0);
    send(32'h40800000, 3'd0, 1'b0, 5'd4, 1'b0, 32'h0, 5'h0);
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h41200000, 3'd0, 1'b0, 5'd7, 1'b0, 32'h0, 5'h0);
    send(32'h41300000, 3'd0, 1'b0, 5'd8, 1'b0, 32'h0, 5'h0);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL fill out_valid=%b in_ready=%b required 1,0", out_valid, in_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_valid64 !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid out_valid=%b in_ready=%b required 0,1", out_valid, in_ready);
    end
    q32.delete();
    q64.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL after_reset cycle=%0d out_valid=%b in_ready=%b required 0,1", c, out_valid, in_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0]  ex;
    logic [22:0] man;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) ex = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else                            ex = 8'($urandom_range(110, 200));
      man = 23'($urandom);
      if ($urandom_range(0, 3) == 0) man = man & 23'h7F0000;
      out_ready = ($urandom_range(0, 3) != 0);
      send({1'($urandom), ex, man}, 3'($urandom_range(0, 7)), 1'($urandom), 5'(i),
           1'b0, 32'h0, 5'h0);
    end
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; float_in = 32'h0; rm = 3'd0;
    is_unsigned = 1'b0; tag_in = 5'd0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
